camera_follow: RTL and testbench
================================

Name: camera_follow

Overview:
- Produces the camera_x / camera_y world offsets consumed by render, directly upstream of it.
- Once per video frame, on the new-frame pulse from video_sig_gen, moves the camera toward the tracked car position.
- Motion uses a dead-zone plus a per-frame step limit, and the result is clamped to world bounds.
- Outputs change only in a single commit cycle, so render never sees a mid-frame camera change.

Parameters:
- COORD_WIDTH, 32, width of signed world coordinates
- SCREEN_W, 1280, visible width in pixels
- SCREEN_H, 720, visible height in pixels
- WORLD_W, 4096, world width in pixels (must be ≥ SCREEN_W)
- WORLD_H, 4096, world height in pixels (must be ≥ SCREEN_H)
- DEADZONE_X, 64, horizontal half-width of the no-move zone around screen centre
- DEADZONE_Y, 48, vertical half-height of the no-move zone
- MAX_STEP, 16, maximum camera move per frame per axis, in pixels
- INIT_X, 0, camera_x after reset
- INIT_Y, 0, camera_y after reset

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  synchronous active-high reset
- new_frame_in  input  1  one-cycle new-frame pulse from video_sig_gen
- target_x_in  input  COORD_WIDTH  signed car x in world coordinates
- target_y_in  input  COORD_WIDTH  signed car y in world coordinates
- recenter_in  input  1  level; when sampled with new_frame_in, snap without step limit
- camera_x_out  output  COORD_WIDTH  signed top-left x of view
- camera_y_out  output  COORD_WIDTH  signed top-left y of view
- update_out  output  1  one-cycle pulse in the cycle after camera outputs change
- busy_out  output  1  high while not IDLE
- overrun_out  output  1  sticky; new_frame_in arrived while busy

Behaviour:
- Single clock clk_in. Reset rst_in is synchronous, active-high.
- Reset values: camera_x_out=INIT_X, camera_y_out=INIT_Y, update_out=0, busy_out=0, overrun_out=0, state=IDLE.
- Reset mid-operation: the computation is aborted and all outputs return to reset values the next cycle.
- FSM states: IDLE → LATCH → STEP → CLAMP → COMMIT → IDLE. There is one cycle per state.
- IDLE: on new_frame_in=1, register target_x_in, target_y_in and recenter_in, then go to LATCH.
- LATCH: compute the error from the camera centre:
  - ex = tx − (camera_x_out + SCREEN_W/2)
  - ey = ty − (camera_y_out + SCREEN_H/2)
- STEP, per axis (x shown; y uses DEADZONE_Y):
  - If recenter: step = ex.
  - Else if |ex| ≤ DEADZONE_X: step = 0.
  - Else: step = ex − sign(ex)·DEADZONE_X, saturated to [−MAX_STEP, +MAX_STEP].
  - nx = camera_x_out + step.
- CLAMP: nx saturated to [0, WORLD_W−SCREEN_W]; ny saturated to [0, WORLD_H−SCREEN_H].
- COMMIT: register nx/ny into the camera outputs.
  - update_out=1 in the cycle after COMMIT (aligned with the new output values).
  - Then return to IDLE.
- Latency: outputs change 4 cycles after the new_frame_in cycle. This is well inside vertical blanking.
- Arithmetic: all intermediates are signed with width COORD_WIDTH+2, so sums and differences never wrap. Only saturation narrows back to COORD_WIDTH.
- new_frame_in while busy_out=1: the pulse is ignored, overrun_out is set, and it clears only on reset.
- Target inputs are sampled only in IDLE; changes at other times have no effect.
- busy_out=1 in LATCH, STEP, CLAMP and COMMIT.

Decomposition:
- Package camera_pkg holds:
  - the state enum cam_state_t (IDLE, LATCH, STEP, CLAMP, COMMIT)
  - the coordinate typedef coord_t (signed, COORD_WIDTH)
  - the default screen and world constants shared with render
- One sub-module is natural: axis_step. It is combinational, computes deadzone + step-limit + clamp for one axis, and is instantiated twice (x, y) with per-axis parameters.

Test Plan:
- Reset, then target (640,360) with new_frame_in pulse → error 0; camera stays (0,0), update_out pulses at cycle +4.
- From cam (0,0), target (1000,360), one frame → ex=360 > 64, step=min(296,16)=16 → camera_x_out=16, camera_y_out=0.
- Same target with recenter_in=1 → camera_x_out=360 in one frame. Target (5000,5000) with recenter → clamped to (2816,3376).
- Target (−500,−500) from cam (8,8) → step clamps to −16, then bounds clamp → camera (0,0).
- new_frame_in pulsed at cycle +2 after a first pulse → second pulse ignored, overrun_out=1, exactly one update_out.
- rst_in asserted in STEP state → next cycle camera outputs are (INIT_X,INIT_Y), busy_out=0, overrun_out=0.

Source files
------------

// File: rtl/camera_pkg.sv
// Shared camera types and the default screen/world geometry used by camera_follow and render.
package camera_pkg;

  localparam int COORD_WIDTH = 32;
  localparam int SCREEN_W    = 1280;
  localparam int SCREEN_H    = 720;
  localparam int WORLD_W     = 4096;
  localparam int WORLD_H     = 4096;

  typedef logic signed [COORD_WIDTH-1:0] coord_t;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StStep,
    StClamp,
    StCommit
  } cam_state_t;

endpackage

// File: rtl/axis_step.sv
// One camera axis: dead-zone and step-limited move toward the target, and clamping to world bounds.
module axis_step #(
  parameter int COORD_WIDTH = 32,
  parameter int DEADZONE    = 64,
  parameter int MAX_STEP    = 16,
  parameter int MAX_POS     = 2816
) (
  input  logic signed [COORD_WIDTH+1:0] err,
  input  logic signed [COORD_WIDTH+1:0] cam,
  input  logic                          recenter,
  input  logic signed [COORD_WIDTH+1:0] pos,
  output logic signed [COORD_WIDTH+1:0] next_pos,
  output logic signed [COORD_WIDTH-1:0] clamped
);

  localparam int W = COORD_WIDTH + 2;
  localparam logic signed [W-1:0] DZ   = W'(DEADZONE);
  localparam logic signed [W-1:0] MS   = W'(MAX_STEP);
  localparam logic signed [W-1:0] MAXP = W'(MAX_POS);

  logic signed [W-1:0] mag;
  logic signed [W-1:0] excess;
  logic signed [W-1:0] step;

  always_comb begin
    mag    = (err < 0) ? -err : err;
    excess = (err < 0) ? (err + DZ) : (err - DZ);
    step   = '0;
    if (recenter) begin
      step = err;
    end else if (mag > DZ) begin
      if (excess > MS) begin
        step = MS;
      end else if (excess < -MS) begin
        step = -MS;
      end else begin
        step = excess;
      end
    end
    next_pos = cam + step;
  end

  always_comb begin
    clamped = '0;
    if (pos < 0) begin
      clamped = '0;
    end else if (pos > MAXP) begin
      clamped = MAXP[COORD_WIDTH-1:0];
    end else begin
      clamped = pos[COORD_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/camera_follow.sv
// Once per frame, moves the camera toward the tracked car and commits the new view in one cycle.
module camera_follow
  import camera_pkg::*;
#(
  parameter int COORD_WIDTH = camera_pkg::COORD_WIDTH,
  parameter int SCREEN_W    = camera_pkg::SCREEN_W,
  parameter int SCREEN_H    = camera_pkg::SCREEN_H,
  parameter int WORLD_W     = camera_pkg::WORLD_W,
  parameter int WORLD_H     = camera_pkg::WORLD_H,
  parameter int DEADZONE_X  = 64,
  parameter int DEADZONE_Y  = 48,
  parameter int MAX_STEP    = 16,
  parameter int INIT_X      = 0,
  parameter int INIT_Y      = 0
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   new_frame_in,
  input  logic [COORD_WIDTH-1:0] target_x_in,
  input  logic [COORD_WIDTH-1:0] target_y_in,
  input  logic                   recenter_in,
  output logic [COORD_WIDTH-1:0] camera_x_out,
  output logic [COORD_WIDTH-1:0] camera_y_out,
  output logic                   update_out,
  output logic                   busy_out,
  output logic                   overrun_out
);

  localparam int W = COORD_WIDTH + 2;
  localparam logic signed [W-1:0] HALF_W = W'(SCREEN_W / 2);
  localparam logic signed [W-1:0] HALF_H = W'(SCREEN_H / 2);

  cam_state_t state;
  logic signed [W-1:0] tx_q, ty_q, ex_q, ey_q, nx_q, ny_q;
  logic signed [COORD_WIDTH-1:0] cx_q, cy_q;
  logic recenter_q;

  logic signed [W-1:0] cam_x, cam_y, nx_d, ny_d;
  logic signed [COORD_WIDTH-1:0] cx_d, cy_d;

  assign cam_x = W'(signed'(camera_x_out));
  assign cam_y = W'(signed'(camera_y_out));

  axis_step #(
    .COORD_WIDTH(COORD_WIDTH),
    .DEADZONE   (DEADZONE_X),
    .MAX_STEP   (MAX_STEP),
    .MAX_POS    (WORLD_W - SCREEN_W)
  ) u_step_x (
    .err     (ex_q),
    .cam     (cam_x),
    .recenter(recenter_q),
    .pos     (nx_q),
    .next_pos(nx_d),
    .clamped (cx_d)
  );

  axis_step #(
    .COORD_WIDTH(COORD_WIDTH),
    .DEADZONE   (DEADZONE_Y),
    .MAX_STEP   (MAX_STEP),
    .MAX_POS    (WORLD_H - SCREEN_H)
  ) u_step_y (
    .err     (ey_q),
    .cam     (cam_y),
    .recenter(recenter_q),
    .pos     (ny_q),
    .next_pos(ny_d),
    .clamped (cy_d)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= StIdle;
      tx_q         <= '0;
      ty_q         <= '0;
      recenter_q   <= 1'b0;
      ex_q         <= '0;
      ey_q         <= '0;
      nx_q         <= '0;
      ny_q         <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      camera_x_out <= COORD_WIDTH'(INIT_X);
      camera_y_out <= COORD_WIDTH'(INIT_Y);
      update_out   <= 1'b0;
      busy_out     <= 1'b0;
      overrun_out  <= 1'b0;
    end else begin
      update_out <= 1'b0;
      // A frame pulse that lands mid-computation is dropped but remembered.
      if (new_frame_in && state != StIdle) begin
        overrun_out <= 1'b1;
      end
      unique case (state)
        StIdle: begin
          if (new_frame_in) begin
            tx_q       <= W'(signed'(target_x_in));
            ty_q       <= W'(signed'(target_y_in));
            recenter_q <= recenter_in;
            busy_out   <= 1'b1;
            state      <= StLatch;
          end
        end
        StLatch: begin
          ex_q  <= tx_q - (cam_x + HALF_W);
          ey_q  <= ty_q - (cam_y + HALF_H);
          state <= StStep;
        end
        StStep: begin
          nx_q  <= nx_d;
          ny_q  <= ny_d;
          state <= StClamp;
        end
        StClamp: begin
          cx_q  <= cx_d;
          cy_q  <= cy_d;
          state <= StCommit;
        end
        StCommit: begin
          camera_x_out <= cx_q;
          camera_y_out <= cy_q;
          update_out   <= 1'b1;
          busy_out     <= 1'b0;
          state        <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_follow.sv
// Directed self-checking bench for camera_follow with default geometry.
module tb_camera_follow;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        new_frame = 1'b0;
  logic [31:0] tx = '0;
  logic [31:0] ty = '0;
  logic        recenter = 1'b0;
  logic [31:0] cam_x, cam_y;
  logic        update, busy, overrun;

  int checks = 0;
  int fails  = 0;

  camera_follow dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .new_frame_in(new_frame),
    .target_x_in (tx),
    .target_y_in (ty),
    .recenter_in (recenter),
    .camera_x_out(cam_x),
    .camera_y_out(cam_y),
    .update_out  (update),
    .busy_out    (busy),
    .overrun_out (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses one frame and returns the number of cycles until update_out (99 on timeout).
  task automatic run_frame(input int x, input int y, input logic rc, output int lat);
    int n;
    tx        = x;
    ty        = y;
    recenter  = rc;
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    n = 0;
    while (!update && n < 10) begin
      tick();
      n++;
    end
    lat = update ? n : 99;
    recenter = 1'b0;
  endtask

  task automatic expect_cam(input string name, input int ex, input int ey, input int lat);
    checks++;
    if (lat == 99) begin
      fails++;
      $display("FAIL %s: update_out never pulsed", name);
    end
    checks++;
    if (cam_x !== ex[31:0] || cam_y !== ey[31:0]) begin
      fails++;
      $display("FAIL %s: camera=(%0d,%0d) expected (%0d,%0d)", name, $signed(cam_x),
               $signed(cam_y), ex, ey);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (cam_x !== 32'd0 || cam_y !== 32'd0 || update !== 1'b0 || busy !== 1'b0 ||
        overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset: cam=(%0d,%0d) upd=%b busy=%b ovr=%b expected (0,0) 0 0 0",
               cam_x, cam_y, update, busy, overrun);
    end
  endtask

  task automatic test_center();
    int lat;
    tx = 640;
    ty = 360;
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL center_busy: busy=%b expected 1", busy);
    end
    lat = 0;
    while (!update && lat < 10) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL center_latency: %0d cycles expected 4", lat);
    end
    expect_cam("center", 0, 0, update ? lat : 99);
    tick();
    checks++;
    if (update !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL center_idle: upd=%b busy=%b expected 0 0", update, busy);
    end
  endtask

  task automatic test_deadzone();
    int lat;
    run_frame(640 + 64, 360 + 48, 1'b0, lat);
    expect_cam("deadzone_edge", 0, 0, lat);
    run_frame(640 + 65, 360 + 49, 1'b0, lat);
    expect_cam("deadzone_plus1", 1, 1, lat);
  endtask

  task automatic test_step();
    int lat;
    tx = 1000;
    ty = 360;
    recenter = 1'b0;
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    // Targets must be ignored once the frame has been latched.
    tx = 9000;
    ty = -9000;
    recenter = 1'b1;
    lat = 0;
    while (!update && lat < 10) begin
      tick();
      lat++;
    end
    recenter = 1'b0;
    expect_cam("step_limit", 17, 1, update ? lat : 99);
  endtask

  task automatic test_recenter();
    int lat;
    run_frame(1000, 360, 1'b1, lat);
    expect_cam("recenter", 360, 0, lat);
    run_frame(5000, 5000, 1'b1, lat);
    expect_cam("recenter_clamp_hi", 2816, 3376, lat);
  endtask

  task automatic test_negative();
    int lat;
    run_frame(648, 368, 1'b1, lat);
    expect_cam("snap_8_8", 8, 8, lat);
    run_frame(-500, -500, 1'b0, lat);
    expect_cam("clamp_lo", 0, 0, lat);
  endtask

  task automatic test_overrun();
    int ups;
    tx = 1000;
    ty = 1000;
    recenter = 1'b1;
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    recenter = 1'b0;
    tick();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    ups = 0;
    for (int i = 0; i < 12; i++) begin
      if (update) ups++;
      tick();
    end
    checks++;
    if (ups !== 1) begin
      fails++;
      $display("FAIL overrun_updates: %0d pulses expected 1", ups);
    end
    checks++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_flag: %b expected 1", overrun);
    end
    expect_cam("overrun_cam", 360, 640, 0);
  endtask

  task automatic test_reset_mid();
    int ups;
    tx = 2000;
    ty = 2000;
    recenter = 1'b1;
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    recenter = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (cam_x !== 32'd0 || cam_y !== 32'd0 || busy !== 1'b0 || overrun !== 1'b0 ||
        update !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: cam=(%0d,%0d) busy=%b ovr=%b upd=%b expected (0,0) 0 0 0",
               cam_x, cam_y, busy, overrun, update);
    end
    ups = 0;
    for (int i = 0; i < 8; i++) begin
      if (update) ups++;
      tick();
    end
    checks++;
    if (ups !== 0 || cam_x !== 32'd0) begin
      fails++;
      $display("FAIL reset_abort: %0d updates cam_x=%0d expected 0 0", ups, cam_x);
    end
  endtask

  initial begin
    test_reset();
    test_center();
    test_deadzone();
    test_step();
    test_recenter();
    test_negative();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
